// File: rtl/pipe_wb_regfile.sv
// Write-back stage register file with per-register pending-write scoreboard.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through on reads and busy flags.
module pipe_wb_regfile #(
   parameter int CNT_W = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wwreg,
   input  logic        wm2reg,
   input  logic [31:0] walu,
   input  logic [31:0] wmo,
   input  logic [4:0]  wrn,
   input  logic [4:0]  rna,
   input  logic [4:0]  rnb,
   output logic [31:0] qa,
   output logic [31:0] qb,
   output logic [31:0] wdi,
   input  logic        iss_wreg,
   input  logic [4:0]  iss_rn,
   output logic        busya,
   output logic        busyb,
   output logic        sb_err
);

   localparam logic [CNT_W-1:0] cntMax = '1;
   localparam logic [CNT_W-1:0] cntOne = 1;

   logic [31:0]      regs    [0:31];
   logic [CNT_W-1:0] cnt     [0:31];
   logic [CNT_W-1:0] cntNext [0:31];
   logic [31:0]      incVec;
   logic [31:0]      decVec;
   logic             commit;
   logic             errHit;

   assign wdi    = wm2reg ? wmo : walu;
   assign commit = wwreg && (wrn != 5'd0);

   // r0 is masked out of both vectors so its counter stays at zero forever
   assign incVec = (iss_wreg && (iss_rn != 5'd0)) ? (32'd1 << iss_rn) : 32'd0;
   assign decVec = commit ? (32'd1 << wrn) : 32'd0;

   // Register array; r0 is cleared at reset and never written, so it reads 0
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[wrn] <= wdi;
      end
   end

   // Saturating counters; a same-cycle issue and retire cancel out
   always_comb begin
      errHit = 1'b0;
      for (int r = 0; r < 32; r++) begin
         cntNext[r] = cnt[r];
         case ({incVec[r], decVec[r]})
            2'b10: begin
               if (cnt[r] == cntMax) errHit = 1'b1;
               else cntNext[r] = cnt[r] + cntOne;
            end
            2'b01: begin
               if (cnt[r] == '0) errHit = 1'b1;
               else cntNext[r] = cnt[r] - cntOne;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= '0;
         end
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= cntNext[r];
         end
         if (errHit) sb_err <= 1'b1;
      end
   end

`ifdef WB_REGFILE_BYPASS_EN
   logic [CNT_W-1:0] cntRet [0:31];

   // Count after this cycle's retire only; a new issue becomes visible next cycle
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         cntRet[r] = (decVec[r] && !incVec[r] && (cnt[r] != '0)) ? cnt[r] - cntOne : cnt[r];
      end
   end

   assign qa    = (commit && (wrn == rna)) ? wdi : regs[rna];
   assign qb    = (commit && (wrn == rnb)) ? wdi : regs[rnb];
   assign busya = (cntRet[rna] != '0) && (rna != 5'd0);
   assign busyb = (cntRet[rnb] != '0) && (rnb != 5'd0);
`else
   assign qa    = regs[rna];
   assign qb    = regs[rnb];
   assign busya = (cnt[rna] != '0) && (rna != 5'd0);
   assign busyb = (cnt[rnb] != '0) && (rnb != 5'd0);
`endif

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Directed self-checking bench for pipe_wb_regfile (CNT_W=2), both bypass builds.
module tb_pipe_wb_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        wwreg;
   logic        wm2reg;
   logic [31:0] walu;
   logic [31:0] wmo;
   logic [4:0]  wrn;
   logic [4:0]  rna;
   logic [4:0]  rnb;
   logic [31:0] qa;
   logic [31:0] qb;
   logic [31:0] wdi;
   logic        iss_wreg;
   logic [4:0]  iss_rn;
   logic        busya;
   logic        busyb;
   logic        sb_err;

   int errors = 0;
   int checks = 0;

   pipe_wb_regfile #(.CNT_W(2)) dut (
      .clock(clock), .reset(reset),
      .wwreg(wwreg), .wm2reg(wm2reg), .walu(walu), .wmo(wmo), .wrn(wrn),
      .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .wdi(wdi),
      .iss_wreg(iss_wreg), .iss_rn(iss_rn),
      .busya(busya), .busyb(busyb), .sb_err(sb_err)
   );

   always #5 clock = ~clock;

   // Drive one cycle's worth of issue/write-back inputs
   task automatic applyStimulus(input logic iss, input logic [4:0] issRn,
                                input logic wr, input logic [4:0] wrRn,
                                input logic m2r, input logic [31:0] alu,
                                input logic [31:0] mo);
      iss_wreg = iss;
      iss_rn   = issRn;
      wwreg    = wr;
      wrn      = wrRn;
      wm2reg   = m2r;
      walu     = alu;
      wmo      = mo;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      rna = 5'd0;
      rnb = 5'd0;
      idle();
      step();
      step();
      reset = 1'b0;

      // Reset state
      rna = 5'd5;
      rnb = 5'd9;
      #1;
      checkOutput("rst_qa", qa, 32'd0);
      checkOutput("rst_busya", {31'd0, busya}, 32'd0);
      checkOutput("rst_sb_err", {31'd0, sb_err}, 32'd0);

      // Preload r5=0x1234 with one outstanding write, then reset
      applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 32'h0000_1234, 32'd0);
      step();
      idle();
      #1;
      checkOutput("preload_qa", qa, 32'h0000_1234);
      checkOutput("preload_busya", {31'd0, busya}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checkOutput("reset_qa", qa, 32'd0);
      checkOutput("reset_busya", {31'd0, busya}, 32'd0);
      checkOutput("reset_sb_err", {31'd0, sb_err}, 32'd0);

      // Commit selection on r7 (issue alongside so the scoreboard stays balanced)
      rna = 5'd7;
      rnb = 5'd7;
      applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 32'hAAAA_0000, 32'h5555_FFFF);
      #1;
      checkOutput("wdi_mem", wdi, 32'h5555_FFFF);
      step();
      checkOutput("r7_mem_qa", qa, 32'h5555_FFFF);
      checkOutput("r7_mem_qb", qb, 32'h5555_FFFF);
      applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 32'hAAAA_0000, 32'h5555_FFFF);
      #1;
      checkOutput("wdi_alu", wdi, 32'hAAAA_0000);
      step();
      idle();
      #1;
      checkOutput("r7_alu_qa", qa, 32'hAAAA_0000);
      checkOutput("r7_busya", {31'd0, busya}, 32'd0);
      checkOutput("r7_sb_err", {31'd0, sb_err}, 32'd0);

      // r0 protection
      rna = 5'd0;
      rnb = 5'd0;
      applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd0);
      #1;
      checkOutput("r0_wdi", wdi, 32'hFFFF_FFFF);
      checkOutput("r0_qa_same", qa, 32'd0);
      step();
      idle();
      #1;
      checkOutput("r0_qa", qa, 32'd0);
      checkOutput("r0_busya", {31'd0, busya}, 32'd0);
      checkOutput("r0_sb_err", {31'd0, sb_err}, 32'd0);

      // Scoreboard sequence on r9
      rna = 5'd9;
      rnb = 5'd7;
      applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("r9_busya_pre", {31'd0, busya}, 32'd0);
      step();
      checkOutput("r9_busya_1", {31'd0, busya}, 32'd1);
      step();
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0000_0099, 32'd0);
      #1;
      checkOutput("r9_busya_2", {31'd0, busya}, 32'd1);
      checkOutput("r9_busyb_r7", {31'd0, busyb}, 32'd0);
      step();
      checkOutput("r9_ret1_busya", {31'd0, busya}, 32'd1);
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 32'd0, 32'h0000_0999);
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      checkOutput("r9_ret2_busya_same", {31'd0, busya}, 32'd0);
`else
      checkOutput("r9_ret2_busya_same", {31'd0, busya}, 32'd1);
`endif
      step();
      checkOutput("r9_ret2_busya", {31'd0, busya}, 32'd0);
      checkOutput("r9_ret2_qa", qa, 32'h0000_0999);
      checkOutput("r9_ret2_sb_err", {31'd0, sb_err}, 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0000_0009, 32'd0);
      step();
      idle();
      #1;
      checkOutput("r9_underflow", {31'd0, sb_err}, 32'd1);
      checkOutput("r9_underflow_busya", {31'd0, busya}, 32'd0);
      step();
      step();
      checkOutput("r9_sticky", {31'd0, sb_err}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checkOutput("r9_err_cleared", {31'd0, sb_err}, 32'd0);

      // Overflow: fourth issue to r12 without any retire
      rna = 5'd12;
      applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      step();
      checkOutput("r12_three_sb_err", {31'd0, sb_err}, 32'd0);
      checkOutput("r12_three_busya", {31'd0, busya}, 32'd1);
      step();
      idle();
      #1;
      checkOutput("r12_overflow", {31'd0, sb_err}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;

      // Simultaneous issue and retire on r3
      rna = 5'd3;
      rnb = 5'd3;
      applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 32'h0BAD_0003, 32'd0);
      step();
      applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      step();
      checkOutput("r3_cnt1_busya", {31'd0, busya}, 32'd1);
      applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 32'h1111_0003, 32'd0);
      #1;
      checkOutput("r3_simul_busya_same", {31'd0, busya}, 32'd1);
      step();
      checkOutput("r3_simul_busya", {31'd0, busya}, 32'd1);
      checkOutput("r3_simul_qa", qa, 32'h1111_0003);
      checkOutput("r3_simul_sb_err", {31'd0, sb_err}, 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 32'hCAFE_0001, 32'd0);
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      checkOutput("r3_bypass_qa", qa, 32'hCAFE_0001);
      checkOutput("r3_bypass_qb", qb, 32'hCAFE_0001);
      checkOutput("r3_bypass_busya", {31'd0, busya}, 32'd0);
`else
      checkOutput("r3_nobypass_qa", qa, 32'h1111_0003);
      checkOutput("r3_nobypass_qb", qb, 32'h1111_0003);
      checkOutput("r3_nobypass_busya", {31'd0, busya}, 32'd1);
`endif
      step();
      idle();
      #1;
      checkOutput("r3_final_qa", qa, 32'hCAFE_0001);
      checkOutput("r3_final_busya", {31'd0, busya}, 32'd0);
      checkOutput("r3_final_sb_err", {31'd0, sb_err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
